// File: rtl/veda_mem_pkg.sv
// +-----------------------------------------------------------------------+
// | veda_mem_pkg : shared widths, op codes and state encoding             |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package veda_mem_pkg;

  localparam int VEDA_AW = 6;
  localparam int VEDA_DW = 8;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_FILL  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WRITE    = 3'd1;
  localparam logic [2:0] ST_FILL     = 3'd2;
  localparam logic [2:0] ST_RD_ISSUE = 3'd3;
  localparam logic [2:0] ST_RD_WAIT  = 3'd4;
  localparam logic [2:0] ST_RSP      = 3'd5;
  localparam logic [2:0] ST_VFY_WAIT = 3'd6;

endpackage

`default_nettype wire

// File: rtl/veda_mem_seq_lat_cnt.sv
// +-----------------------------------------------------------------------+
// | veda_lat_cnt : loadable down-counter that saturates at zero           |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module veda_lat_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  localparam logic [W-1:0] c_ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - c_ONE;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/veda_mem_seq.sv
// +-----------------------------------------------------------------------+
// | veda_mem_seq : WRITE/READ/FILL command sequencer for the 64x8 memory  |
// | Optional read-back verify: define VEDA_SEQ_VERIFY_EN.  Rev 1.0        |
// +-----------------------------------------------------------------------+
`default_nettype none

module veda_mem_seq
  import veda_mem_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic [1:0]         i_cmd_op,
  input  logic [VEDA_AW-1:0] i_cmd_addr,
  input  logic [VEDA_AW-1:0] i_cmd_len,
  input  logic [VEDA_DW-1:0] i_cmd_data,
  input  logic               i_cmd_mode,
  output logic               o_rsp_valid,
  input  logic               i_rsp_ready,
  output logic [VEDA_DW-1:0] o_rsp_data,
  output logic [VEDA_AW-1:0] o_rsp_addr,
  output logic               o_mem_we,
  output logic [VEDA_AW-1:0] o_mem_address_a,
  output logic [VEDA_AW-1:0] o_mem_address_b,
  output logic [VEDA_DW-1:0] o_mem_dataIn,
  output logic               o_mem_Mode,
  input  logic [VEDA_DW-1:0] i_mem_dataOut,
  output logic               o_busy,
  output logic               o_err
);

  localparam logic [2:0]         c_LAT = 3'(RD_LAT);
  localparam logic [VEDA_AW-1:0] c_A1  = {{(VEDA_AW-1){1'b0}}, 1'b1};

  state_t             r_state;
  state_t             w_next;
  logic               r_cmd_ready;
  logic               r_busy;
  logic               r_rsp_valid;
  logic               r_err;
  logic               r_we;
  logic               r_mode;
  logic [VEDA_AW-1:0] r_addr_a;
  logic [VEDA_AW-1:0] r_addr_b;
  logic [VEDA_AW-1:0] r_len;
  logic [VEDA_DW-1:0] r_din;
  logic [VEDA_DW-1:0] r_rsp_data;
  logic [VEDA_AW-1:0] r_rsp_addr;
  logic               w_accept;
  logic               w_cnt_load;
  logic               w_cnt_zero;

  assign w_accept = i_cmd_valid & r_cmd_ready;

`ifdef VEDA_SEQ_VERIFY_EN
  assign w_cnt_load = (r_state == ST_RD_ISSUE) | (r_state == ST_WRITE) | (r_state == ST_FILL);
`else
  assign w_cnt_load = (r_state == ST_RD_ISSUE);
`endif

  veda_lat_cnt #(.W(3)) u_lat_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_cnt_load),
    .i_load_val (c_LAT),
    .o_zero     (w_cnt_zero)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          case (op_e'(i_cmd_op))
            OP_WRITE: w_next = ST_WRITE;
            OP_READ:  w_next = ST_RD_ISSUE;
            OP_FILL:  w_next = ST_FILL;
            default:  w_next = ST_IDLE;
          endcase
        end
      end
      ST_WRITE, ST_FILL: begin
`ifdef VEDA_SEQ_VERIFY_EN
        w_next = ST_VFY_WAIT;
`else
        w_next = (r_len == '0) ? ST_IDLE : ST_FILL;
`endif
      end
      ST_RD_ISSUE: w_next = ST_RD_WAIT;
      ST_RD_WAIT:  if (w_cnt_zero) w_next = ST_RSP;
      ST_RSP:      if (i_rsp_ready) w_next = ST_IDLE;
`ifdef VEDA_SEQ_VERIFY_EN
      ST_VFY_WAIT: if (w_cnt_zero) w_next = (r_len == '0) ? ST_IDLE : ST_FILL;
`endif
      default:     w_next = ST_IDLE;
    endcase
  end

  // WRITE is carried as a one-word FILL (r_len = 0) so both share the write path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_err       <= 1'b0;
      r_we        <= 1'b0;
      r_mode      <= 1'b0;
      r_addr_a    <= '0;
      r_addr_b    <= '0;
      r_len       <= '0;
      r_din       <= '0;
      r_rsp_data  <= '0;
      r_rsp_addr  <= '0;
    end else begin
      r_state     <= w_next;
      r_cmd_ready <= (w_next == ST_IDLE);
      r_busy      <= (w_next != ST_IDLE);
      r_rsp_valid <= (w_next == ST_RSP);
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_mode <= i_cmd_mode;
            case (op_e'(i_cmd_op))
              OP_WRITE, OP_FILL: begin
                r_we     <= 1'b1;
                r_addr_a <= i_cmd_addr;
                r_din    <= i_cmd_data;
                r_len    <= (op_e'(i_cmd_op) == OP_FILL) ? i_cmd_len : '0;
              end
              OP_READ: r_addr_b <= i_cmd_addr;
              default: r_err    <= 1'b1;
            endcase
          end
        end
        ST_WRITE, ST_FILL: begin
`ifdef VEDA_SEQ_VERIFY_EN
          r_we     <= 1'b0;
          r_addr_b <= r_addr_a;
`else
          if (r_len == '0) begin
            r_we <= 1'b0;
          end else begin
            r_addr_a <= r_addr_a + c_A1;
            r_len    <= r_len - c_A1;
          end
`endif
        end
        ST_RD_WAIT: begin
          if (w_cnt_zero) begin
            r_rsp_data <= i_mem_dataOut;
            r_rsp_addr <= r_addr_b;
          end
        end
`ifdef VEDA_SEQ_VERIFY_EN
        ST_VFY_WAIT: begin
          if (w_cnt_zero) begin
            if (i_mem_dataOut != r_din) r_err <= 1'b1;
            if (r_len != '0) begin
              r_we     <= 1'b1;
              r_addr_a <= r_addr_a + c_A1;
              r_len    <= r_len - c_A1;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign o_cmd_ready     = r_cmd_ready;
  assign o_busy          = r_busy;
  assign o_rsp_valid     = r_rsp_valid;
  assign o_rsp_data      = r_rsp_data;
  assign o_rsp_addr      = r_rsp_addr;
  assign o_err           = r_err;
  assign o_mem_we        = r_we;
  assign o_mem_address_a = r_addr_a;
  assign o_mem_address_b = r_addr_b;
  assign o_mem_dataIn    = r_din;
  assign o_mem_Mode      = r_mode;

endmodule

`default_nettype wire

// File: tb/tb_veda_mem_seq.sv
// +-----------------------------------------------------------------------+
// | tb_veda_mem_seq : directed bench for veda_mem_seq with a 64x8 model   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_veda_mem_seq;

  logic       clk;
  logic       rst;
  logic       i_cmd_valid;
  logic       o_cmd_ready;
  logic [1:0] i_cmd_op;
  logic [5:0] i_cmd_addr;
  logic [5:0] i_cmd_len;
  logic [7:0] i_cmd_data;
  logic       i_cmd_mode;
  logic       o_rsp_valid;
  logic       i_rsp_ready;
  logic [7:0] o_rsp_data;
  logic [5:0] o_rsp_addr;
  logic       o_mem_we;
  logic [5:0] o_mem_address_a;
  logic [5:0] o_mem_address_b;
  logic [7:0] o_mem_dataIn;
  logic       o_mem_Mode;
  logic [7:0] i_mem_dataOut;
  logic       o_busy;
  logic       o_err;

  logic [7:0] mem [0:63];
  int         wr_cnt;
  logic       clr;
  int         n_chk;
  int         n_fail;
  int         wc;
  logic [5:0] fa;

  veda_mem_seq #(.RD_LAT(1)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_cmd_valid     (i_cmd_valid),
    .o_cmd_ready     (o_cmd_ready),
    .i_cmd_op        (i_cmd_op),
    .i_cmd_addr      (i_cmd_addr),
    .i_cmd_len       (i_cmd_len),
    .i_cmd_data      (i_cmd_data),
    .i_cmd_mode      (i_cmd_mode),
    .o_rsp_valid     (o_rsp_valid),
    .i_rsp_ready     (i_rsp_ready),
    .o_rsp_data      (o_rsp_data),
    .o_rsp_addr      (o_rsp_addr),
    .o_mem_we        (o_mem_we),
    .o_mem_address_a (o_mem_address_a),
    .o_mem_address_b (o_mem_address_b),
    .o_mem_dataIn    (o_mem_dataIn),
    .o_mem_Mode      (o_mem_Mode),
    .i_mem_dataOut   (i_mem_dataOut),
    .o_busy          (o_busy),
    .o_err           (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: synchronous write, one-cycle registered read.
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
      wr_cnt        <= 0;
      i_mem_dataOut <= 8'h00;
    end else begin
      if (o_mem_we) begin
        mem[o_mem_address_a] <= o_mem_dataIn;
        wr_cnt               <= wr_cnt + 1;
      end
`ifdef VEDA_SEQ_VERIFY_EN
      i_mem_dataOut <= mem[o_mem_address_b] ^ ((o_mem_address_b == 6'd23) ? 8'h01 : 8'h00);
`else
      i_mem_dataOut <= mem[o_mem_address_b];
`endif
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [5:0] a, input logic [5:0] len,
                       input logic [7:0] d, input logic m);
    chk("issue_ready", o_cmd_ready, 1);
    i_cmd_op    = op;
    i_cmd_addr  = a;
    i_cmd_len   = len;
    i_cmd_data  = d;
    i_cmd_mode  = m;
    i_cmd_valid = 1'b1;
    @(negedge clk);
    i_cmd_valid = 1'b0;
  endtask

  initial begin
    n_chk       = 0;
    n_fail      = 0;
    rst         = 1'b1;
    clr         = 1'b1;
    i_cmd_valid = 1'b0;
    i_cmd_op    = 2'b00;
    i_cmd_addr  = 6'd0;
    i_cmd_len   = 6'd0;
    i_cmd_data  = 8'h00;
    i_cmd_mode  = 1'b0;
    i_rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    chk("rst_ready", o_cmd_ready, 0);
    chk("rst_we", o_mem_we, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_err", o_err, 0);
    chk("rst_rsp_valid", o_rsp_valid, 0);
    chk("rst_addr_a", o_mem_address_a, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", o_cmd_ready, 1);
    chk("idle_busy", o_busy, 0);

    // WRITE 5 <- 27
    issue(2'b00, 6'd5, 6'd0, 8'd27, 1'b0);
    chk("wr_we", o_mem_we, 1);
    chk("wr_addr", o_mem_address_a, 5);
    chk("wr_din", o_mem_dataIn, 27);
    chk("wr_ready_low", o_cmd_ready, 0);
    chk("wr_busy", o_busy, 1);
    @(negedge clk);
    chk("wr_we_off", o_mem_we, 0);
    chk("wr_ready_back", o_cmd_ready, 1);
    chk("wr_addr_hold", o_mem_address_a, 5);
    chk("wr_mem5", mem[5], 27);

    // WRITE 8 <- 26, READ 8
    issue(2'b00, 6'd8, 6'd0, 8'd26, 1'b0);
    @(negedge clk);
    i_rsp_ready = 1'b1;
    issue(2'b01, 6'd8, 6'd0, 8'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("rd_not_early", o_rsp_valid, 0);
    chk("rd_no_we", o_mem_we, 0);
    @(negedge clk);
    chk("rd_valid", o_rsp_valid, 1);
    chk("rd_data", o_rsp_data, 26);
    chk("rd_addr", o_rsp_addr, 8);
    chk("rd_ready_low", o_cmd_ready, 0);
    @(negedge clk);
    chk("rd_valid_drop", o_rsp_valid, 0);
    chk("rd_ready_back", o_cmd_ready, 1);

    // FILL 62 len 3 with wrap
    issue(2'b10, 6'd62, 6'd3, 8'h55, 1'b1);
    chk("fill_mode", o_mem_Mode, 1);
    fa = 6'd62;
    for (int k = 0; k < 4; k++) begin
      chk("fill_we", o_mem_we, 1);
      chk("fill_addr", o_mem_address_a, fa);
      chk("fill_ready_low", o_cmd_ready, 0);
      fa = fa + 6'd1;
      @(negedge clk);
    end
    chk("fill_we_off", o_mem_we, 0);
    chk("fill_ready_back", o_cmd_ready, 1);
    chk("fill_mem63", mem[63], 8'h55);
    chk("fill_mem2", mem[2], 8'h00);
    issue(2'b01, 6'd0, 6'd0, 8'd0, 1'b0);
    repeat (3) @(negedge clk);
    chk("fill_rd_valid", o_rsp_valid, 1);
    chk("fill_rd_data", o_rsp_data, 8'h55);
    @(negedge clk);

    // READ with response back-pressure
    i_rsp_ready = 1'b0;
    issue(2'b01, 6'd62, 6'd0, 8'd0, 1'b0);
    repeat (3) @(negedge clk);
    chk("bp_valid0", o_rsp_valid, 1);
    chk("bp_addr", o_rsp_addr, 62);
    i_cmd_op    = 2'b00;
    i_cmd_addr  = 6'd62;
    i_cmd_data  = 8'h00;
    i_cmd_valid = 1'b1;
    wc = wr_cnt;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", o_rsp_valid, 1);
      chk("bp_data", o_rsp_data, 8'h55);
      chk("bp_ready", o_cmd_ready, 0);
      chk("bp_we", o_mem_we, 0);
    end
    i_cmd_valid = 1'b0;
    i_rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_valid_drop", o_rsp_valid, 0);
    chk("bp_ready_back", o_cmd_ready, 1);
    chk("bp_no_write", wr_cnt, wc);
    chk("bp_mem62", mem[62], 8'h55);

    // Reserved op
    wc = wr_cnt;
    issue(2'b11, 6'd9, 6'd0, 8'hFF, 1'b0);
    chk("rsvd_err", o_err, 1);
    chk("rsvd_ready", o_cmd_ready, 1);
    chk("rsvd_we", o_mem_we, 0);
    @(negedge clk);
    @(negedge clk);
    chk("rsvd_err_sticky", o_err, 1);
    chk("rsvd_busy", o_busy, 0);
    chk("rsvd_no_write", wr_cnt, wc);

    // Reset in the middle of a 10-word FILL
    wc = wr_cnt;
    issue(2'b10, 6'd10, 6'd9, 8'hAA, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("mf_we", o_mem_we, 1);
    chk("mf_addr", o_mem_address_a, 12);
    chk("mf_words", wr_cnt - wc, 2);
    rst = 1'b1;
    #1;
    chk("mf_we_async", o_mem_we, 0);
    chk("mf_busy_async", o_busy, 0);
    chk("mf_err_clr", o_err, 0);
    wc = wr_cnt;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mf_ready", o_cmd_ready, 1);
    chk("mf_busy", o_busy, 0);
    repeat (3) @(negedge clk);
    chk("mf_no_more_writes", wr_cnt, wc);
    chk("mf_mem11", mem[11], 8'hAA);
    chk("mf_mem12", mem[12], 8'h00);
    chk("mf_no_rsp", o_rsp_valid, 0);

`ifdef VEDA_SEQ_VERIFY_EN
    issue(2'b00, 6'd23, 6'd0, 8'd25, 1'b0);
    repeat (6) @(negedge clk);
    chk("vfy_err", o_err, 1);
    chk("vfy_no_rsp", o_rsp_valid, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/veda_mem_seq.md
# veda_mem_seq

Command sequencer that initiates all accesses to the 64x8 `veda_mem_2` memory, replacing bench-driven stimulus with a host-facing valid/ready command port. It accepts WRITE, READ and FILL commands, drives the memory's `we/address_a/address_b/dataIn/Mode` pins, and returns read data through a valid/ready response port. It sits between the host logic and the memory as the memory's sole initiator.

## Interface
- `RD_LAT`, default 1: cycles from `mem_address_b` being driven to valid `mem_dataOut`; legal range 1..4.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: sequencer accepts; high only in IDLE.
- `cmd_op` in 2: 00 WRITE, 01 READ, 10 FILL, 11 reserved.
- `cmd_addr` in 6: target or start address.
- `cmd_len` in 6: FILL word count minus one.
- `cmd_data` in 8: write or fill value.
- `cmd_mode` in 1: value driven on `mem_Mode` for the whole command.
- `rsp_valid` out 1, `rsp_ready` in 1: read-response handshake.
- `rsp_data` out 8: read data.
- `rsp_addr` out 6: address of the read.
- `mem_we`, `mem_address_a` (6), `mem_address_b` (6), `mem_dataIn` (8), `mem_Mode` (1): out, to the memory.
- `mem_dataOut` in 8: from the memory.
- `busy` out 1: not in IDLE.
- `err` out 1: sticky error flag, cleared only by `rst`.

## Operation
- Command accept occurs on a rising edge when `cmd_valid & cmd_ready`. All `cmd_*` fields are latched at accept.
- States: IDLE, WRITE, FILL, RD_ISSUE, RD_WAIT, RSP (plus VFY_* states under the macro).
- IDLE on accept:
  - op 00 goes to WRITE.
  - op 01 goes to RD_ISSUE.
  - op 10 goes to FILL.
  - op 11 is dropped, sets `err`, and stays in IDLE.
- WRITE: one cycle with `mem_we`=1, `mem_address_a`=addr, `mem_dataIn`=data. Returns to IDLE.
- FILL: `mem_we`=1 for exactly `cmd_len`+1 consecutive cycles at addresses addr, addr+1, ... The address counter is 6 bits and wraps 63 to 0. Returns to IDLE after the last write.
  - `cmd_len`=63 writes every location once.
- RD_ISSUE: drives `mem_address_b`=addr with `mem_we`=0. A latency counter is loaded with `RD_LAT`.
- RD_WAIT: counts down. When the count expires, captures `mem_dataOut` into `rsp_data` and goes to RSP.
- RSP: holds `rsp_valid`=1 and stable `rsp_data`/`rsp_addr` until `rsp_ready`. Goes to IDLE on the handshake cycle.
- No responses are produced for WRITE or FILL.
- Idle outputs: when no write is active, `mem_we`=0 and `mem_address_a`/`mem_dataIn` hold their last values.
- Reset mid-operation: an in-flight FILL or READ is abandoned. No response is produced and `mem_we` drops to 0 immediately (asynchronously).

## Timing
- Reset values: `cmd_ready`=0 while `rst` is high, then 1 from the first cycle after deassert (IDLE). All other outputs are 0.
- WRITE: `mem_we` is asserted in the cycle after accept. `cmd_ready` returns the cycle after that, giving a 2-cycle command rate.
- FILL of N words: `mem_we` is high for N cycles starting the cycle after accept. `cmd_ready` returns at accept+N+1.
- READ: `rsp_valid` rises at accept + 2 + `RD_LAT` cycles. With `RD_LAT`=1, a READ accepted at edge 0 gives `rsp_valid` at edge 3.
- `cmd_ready` is low during RSP: back-pressure on `rsp_ready` stalls further commands.
- `busy` = ~IDLE, registered alongside the state.

## Configuration
- `VEDA_SEQ_VERIFY_EN`, defined: every WRITE and every FILL word is followed by a read-back of the same address through `mem_address_b`, waiting `RD_LAT` cycles.
  - A mismatch against the written data sets `err`.
  - FILL then takes (2+`RD_LAT`) cycles per word, and WRITE latency grows likewise.
  - Verify produces no response.
- Undefined: no verify states exist, and timing is exactly as given in the Timing section.

## Structure
- Shared package `veda_mem_pkg` holds:
  - op codes `OP_WRITE`, `OP_READ`, `OP_FILL`, `OP_RSVD`;
  - state encoding typedef;
  - `VEDA_AW`=6 and `VEDA_DW`=8.
- One natural sub-module: `veda_lat_cnt`, the loadable down-counter shared by RD_WAIT and the verify wait.

## Test plan
- Reset, then WRITE addr 5 data 27 → one cycle of `mem_we`=1, `mem_address_a`=5, `mem_dataIn`=27; `cmd_ready` back 2 cycles after accept.
- WRITE 8←26, then READ 8 with `rsp_ready`=1 → `rsp_valid` at accept+3, `rsp_data`=26, `rsp_addr`=8.
- FILL addr 62 len 3 data 0x55 → writes to 62, 63, 0, 1 on consecutive cycles; a subsequent READ of 0 returns 0x55.
- READ with `rsp_ready` held low for 5 cycles → `rsp_data` stable, `cmd_ready`=0, and a new `cmd_valid` is ignored until the handshake.
- op 11 → `err`=1, no memory write, `cmd_ready` remains 1; `err` holds until `rst`.
- `rst` asserted mid-FILL (after 2 of 10 words) → `mem_we`=0 immediately, IDLE after deassert, no further writes. Under `VEDA_SEQ_VERIFY_EN`, a memory model that corrupts address 23 sets `err` after WRITE 23←25.
